// File: rtl/dds_param_ctrl.sv
// dds_param_ctrl: front-panel parameter controller for a DDS core.
// Three debounced active-low keys select and adjust the waveform, frequency
// word, phase offset and amplitude. Up/down keys auto-repeat while held.
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   key_mode_n/key_up_n/key_down_n - debounced keys, low = pressed
//   mode        [1:0]  - selected parameter (0 wave,1 freq,2 phase,3 amp)
//   wave_sel    [1:0]  - waveform (0 sine,1 square,2 triangle,3 saw)
//   freq_word   [31:0] - tuning word, saturating at 0 / FREQ_MAX
//   phase_word  [11:0] - phase offset, modulo 4096
//   amp         [7:0]  - amplitude, saturating at 0 / 255
//   cfg_valid          - one-cycle pulse when any configuration value changed

// Per-key press detection and auto-repeat timing.
//   press - key newly low, and not locked out
//   fire  - auto-repeat step due this cycle
//   kill  - abandon any repeat; a still-held key stays locked until released
module dds_key_rep #(
  parameter logic [23:0] HOLD_CYC   = 24'd5_000_000,
  parameter logic [23:0] REPEAT_CYC = 24'd1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  input  logic kill,
  output logic press,
  output logic fire
);
  logic        key_q, lock, act, rep_ph;
  logic [23:0] cnt;
  logic [23:0] cnt_inc;

  assign cnt_inc = cnt + 24'd1;
  assign press   = !key_n && key_q && !lock;
  assign fire    = act && !key_n && (cnt_inc == (rep_ph ? REPEAT_CYC : HOLD_CYC));

  always_ff @(posedge clk) begin
    if (rst) begin
      // lock set so a key held through reset needs a release first
      key_q  <= 1'b1;
      lock   <= 1'b1;
      act    <= 1'b0;
      rep_ph <= 1'b0;
      cnt    <= '0;
    end else begin
      key_q <= key_n;
      if (key_n) begin
        lock   <= 1'b0;
        act    <= 1'b0;
        rep_ph <= 1'b0;
        cnt    <= '0;
      end else if (kill) begin
        lock   <= 1'b1;
        act    <= 1'b0;
        rep_ph <= 1'b0;
        cnt    <= '0;
      end else if (press) begin
        act    <= 1'b1;
        rep_ph <= 1'b0;
        cnt    <= '0;
      end else if (fire) begin
        rep_ph <= 1'b1;
        cnt    <= '0;
      end else if (act) begin
        cnt    <= cnt_inc;
      end
    end
  end
endmodule

module dds_param_ctrl #(
  parameter logic [31:0] FREQ_STEP  = 32'd1000,
  parameter logic [31:0] FREQ_MAX   = 32'h7FFF_FFFF,
  parameter logic [31:0] FREQ_RST   = 32'd42950,
  parameter logic [11:0] PHASE_STEP = 12'd256,
  parameter logic [7:0]  AMP_STEP   = 8'd16,
  parameter logic [23:0] HOLD_CYC   = 24'd5_000_000,
  parameter logic [23:0] REPEAT_CYC = 24'd1_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_mode_n,
  input  logic        key_up_n,
  input  logic        key_down_n,
  output logic [1:0]  mode,
  output logic [1:0]  wave_sel,
  output logic [31:0] freq_word,
  output logic [11:0] phase_word,
  output logic [7:0]  amp,
  output logic        cfg_valid
);
  logic mode_q, mode_lock, mode_ev, both, kill;
  logic up_ev, up_fire, dn_ev, dn_fire, step_up, step_dn;

  assign mode_ev = !key_mode_n && mode_q && !mode_lock;
  assign both    = !key_up_n && !key_down_n;
  assign kill    = mode_ev || both;
  assign step_up = (up_ev || up_fire) && !kill;
  assign step_dn = (dn_ev || dn_fire) && !kill;

  dds_key_rep #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_up (
    .clk(clk), .rst(rst), .key_n(key_up_n), .kill(kill), .press(up_ev), .fire(up_fire));
  dds_key_rep #(.HOLD_CYC(HOLD_CYC), .REPEAT_CYC(REPEAT_CYC)) u_dn (
    .clk(clk), .rst(rst), .key_n(key_down_n), .kill(kill), .press(dn_ev), .fire(dn_fire));

  // one guard bit on each saturating path: overflow shows as > limit, underflow as bit 32/8 set
  logic [32:0] f_inc, f_dec;
  logic [8:0]  a_inc, a_dec;
  assign f_inc = {1'b0, freq_word} + {1'b0, FREQ_STEP};
  assign f_dec = {1'b0, freq_word} - {1'b0, FREQ_STEP};
  assign a_inc = {1'b0, amp} + {1'b0, AMP_STEP};
  assign a_dec = {1'b0, amp} - {1'b0, AMP_STEP};

  logic [1:0]  wave_nx;
  logic [31:0] freq_nx;
  logic [11:0] phase_nx;
  logic [7:0]  amp_nx;
  logic        chg;

  always_comb begin
    wave_nx  = wave_sel;
    freq_nx  = freq_word;
    phase_nx = phase_word;
    amp_nx   = amp;
    if (step_up) begin
      case (mode)
        2'd0: wave_nx  = wave_sel + 2'd1;
        2'd1: freq_nx  = (f_inc > {1'b0, FREQ_MAX}) ? FREQ_MAX : f_inc[31:0];
        2'd2: phase_nx = phase_word + PHASE_STEP;
        default: amp_nx = a_inc[8] ? 8'd255 : a_inc[7:0];
      endcase
    end else if (step_dn) begin
      case (mode)
        2'd0: wave_nx  = wave_sel - 2'd1;
        2'd1: freq_nx  = f_dec[32] ? 32'd0 : f_dec[31:0];
        2'd2: phase_nx = phase_word - PHASE_STEP;
        default: amp_nx = a_dec[8] ? 8'd0 : a_dec[7:0];
      endcase
    end
    chg = (wave_nx != wave_sel) || (freq_nx != freq_word) ||
          (phase_nx != phase_word) || (amp_nx != amp);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_q     <= 1'b1;
      mode_lock  <= 1'b1;
      mode       <= 2'd0;
      wave_sel   <= 2'd0;
      freq_word  <= FREQ_RST;
      phase_word <= 12'd0;
      amp        <= 8'd128;
      cfg_valid  <= 1'b0;
    end else begin
      mode_q     <= key_mode_n;
      if (key_mode_n) mode_lock <= 1'b0;
      if (mode_ev) mode <= mode + 2'd1;
      wave_sel   <= wave_nx;
      freq_word  <= freq_nx;
      phase_word <= phase_nx;
      amp        <= amp_nx;
      cfg_valid  <= chg;
    end
  end
endmodule

// File: tb/tb_dds_param_ctrl.sv
module tb_dds_param_ctrl;
  typedef struct {
    logic [1:0]  mode;
    logic [1:0]  wave;
    logic [31:0] freq;
    logic [11:0] phase;
    logic [7:0]  amp;
    logic        cv;
  } exp_t;

  localparam logic [2:0] K_NONE = 3'b111, K_MODE = 3'b011, K_UP = 3'b101,
                         K_DN = 3'b110, K_UD = 3'b100, K_MU = 3'b001;
  localparam logic [31:0] F_RST = 32'd42950;

  logic clk = 1'b0, rst = 1'b1;
  logic key_mode_n = 1'b1, key_up_n = 1'b1, key_down_n = 1'b1;
  logic [1:0]  mode, wave_sel;
  logic [31:0] freq_word;
  logic [11:0] phase_word;
  logic [7:0]  amp;
  logic        cfg_valid;

  always #5 clk = ~clk;

  dds_param_ctrl #(.HOLD_CYC(24'd8), .REPEAT_CYC(24'd4)) dut (
    .clk(clk), .rst(rst), .key_mode_n(key_mode_n), .key_up_n(key_up_n),
    .key_down_n(key_down_n), .mode(mode), .wave_sel(wave_sel),
    .freq_word(freq_word), .phase_word(phase_word), .amp(amp), .cfg_valid(cfg_valid));

  int   n_chk = 0, n_err = 0;
  exp_t cur;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // drive keys/reset for one edge, expectation queued with the stimulus
  task automatic tick(input logic [2:0] k, input logic r);
    exp_t e;
    {key_mode_n, key_up_n, key_down_n} = k;
    rst = r;
    sb.push_back(cur);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("mode",      {30'd0, mode},       {30'd0, e.mode});
    chk("wave_sel",  {30'd0, wave_sel},   {30'd0, e.wave});
    chk("freq_word", freq_word,           e.freq);
    chk("phase",     {20'd0, phase_word}, {20'd0, e.phase});
    chk("amp",       {24'd0, amp},        {24'd0, e.amp});
    chk("cfg_valid", {31'd0, cfg_valid},  {31'd0, e.cv});
  endtask

  // one-cycle press then release; cur already holds the post-press values
  task automatic press(input logic [2:0] k);
    tick(k, 1'b0);
    cur.cv = 1'b0;
    tick(K_NONE, 1'b0);
  endtask

  task automatic set_rst_vals();
    cur = '{mode: 2'd0, wave: 2'd0, freq: F_RST, phase: 12'd0, amp: 8'd128, cv: 1'b0};
  endtask

  task automatic next_mode();
    cur.mode = cur.mode + 2'd1;
    cur.cv   = 1'b0;
    press(K_MODE);
  endtask

  initial begin
    logic [7:0] a_nv;
    set_rst_vals();
    tick(K_NONE, 1'b1);
    tick(K_NONE, 1'b1);
    tick(K_NONE, 1'b0);

    // mode then up: freq +1000
    next_mode();
    cur.freq = 32'd43950; cur.cv = 1'b1; press(K_UP);

    // amp up to 240, then clamp at 255
    next_mode(); next_mode();
    for (int i = 0; i < 7; i++) begin
      cur.amp = 8'd144 + 8'(16 * i); cur.cv = 1'b1; press(K_UP);
    end
    cur.amp = 8'd255; cur.cv = 1'b1; press(K_UP);
    cur.cv = 1'b0; press(K_UP);

    // phase up to 3840, wrap to 0, wrap back down
    next_mode(); next_mode(); next_mode();
    for (int i = 1; i <= 15; i++) begin
      cur.phase = 12'(256 * i); cur.cv = 1'b1; press(K_UP);
    end
    cur.phase = 12'd0;    cur.cv = 1'b1; press(K_UP);
    cur.phase = 12'd3840; cur.cv = 1'b1; press(K_DN);

    // amp down to 0 with clamp, final step no pulse
    next_mode();
    for (int i = 0; i < 17; i++) begin
      a_nv = (cur.amp < 8'd16) ? 8'd0 : cur.amp - 8'd16;
      cur.cv = (a_nv != cur.amp);
      cur.amp = a_nv;
      press(K_DN);
    end

    // freq auto-repeat: steps at 0, 8, 12, 16, 20
    next_mode(); next_mode();
    for (int k = 0; k <= 20; k++) begin
      if (k == 0 || k == 8 || k == 12 || k == 16 || k == 20) begin
        cur.freq = cur.freq + 32'd1000; cur.cv = 1'b1;
      end else cur.cv = 1'b0;
      tick(K_UP, 1'b0);
    end
    cur.cv = 1'b0;
    tick(K_NONE, 1'b0);
    chk("freq_after_hold", cur.freq, 32'd48950);

    // up+down together: nothing changes, no repeat while both held
    for (int k = 0; k < 12; k++) tick(K_UD, 1'b0);
    tick(K_NONE, 1'b0);

    // mode+up together at mode 0: mode wins, held up stays silent
    next_mode(); next_mode(); next_mode();
    cur.mode = 2'd1; tick(K_MU, 1'b0);
    for (int k = 0; k < 12; k++) tick(K_UP, 1'b0);
    tick(K_NONE, 1'b0);

    // wave wraps down and up
    next_mode(); next_mode(); next_mode();
    cur.wave = 2'd3; cur.cv = 1'b1; press(K_DN);
    cur.wave = 2'd0; cur.cv = 1'b1; press(K_UP);

    // up held through reset release: needs release and re-press
    set_rst_vals();
    tick(K_UP, 1'b1);
    tick(K_UP, 1'b1);
    for (int k = 0; k < 10; k++) tick(K_UP, 1'b0);
    tick(K_NONE, 1'b0);
    cur.wave = 2'd1; cur.cv = 1'b1; press(K_UP);

    // reset mid-repeat restores everything
    next_mode();
    for (int k = 0; k < 10; k++) begin
      if (k == 0 || k == 8) begin
        cur.freq = cur.freq + 32'd1000; cur.cv = 1'b1;
      end else cur.cv = 1'b0;
      tick(K_UP, 1'b0);
    end
    set_rst_vals();
    tick(K_UP, 1'b1);
    tick(K_NONE, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/dds_param_ctrl.md
DDS_PARAM_CTRL -- requirements
Module: dds_param_ctrl

Interface
REQ-001 SHALL have parameter FREQ_STEP, default 32'd1000, frequency-word increment per step.
REQ-002 SHALL have parameter FREQ_MAX, default 32'h7FFF_FFFF, upper saturation limit of freq_word.
REQ-003 SHALL have parameter FREQ_RST, default 32'd42950, freq_word reset value.
REQ-004 SHALL have parameter PHASE_STEP, default 12'd256, phase-word increment per step (mod 4096).
REQ-005 SHALL have parameter AMP_STEP, default 8'd16, amplitude increment per step.
REQ-006 SHALL have parameter HOLD_CYC, default 24'd5_000_000, hold cycles before auto-repeat.
REQ-007 SHALL have parameter REPEAT_CYC, default 24'd1_000_000, cycles between auto-repeat steps.
REQ-008 SHALL have port clk, input, 1, system clock, all logic on rising edge.
REQ-009 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-010 SHALL have port key_mode_n, input, 1, debounced mode key, low = pressed.
REQ-011 SHALL have port key_up_n, input, 1, debounced increment key, low = pressed.
REQ-012 SHALL have port key_down_n, input, 1, debounced decrement key, low = pressed.
REQ-013 SHALL have port mode, output, 2, selected parameter: 0 wave, 1 freq, 2 phase, 3 amp.
REQ-014 SHALL have port wave_sel, output, 2, waveform select: 0 sine, 1 square, 2 triangle, 3 sawtooth.
REQ-015 SHALL have port freq_word, output, 32, DDS frequency tuning word.
REQ-016 SHALL have port phase_word, output, 12, DDS phase offset.
REQ-017 SHALL have port amp, output, 8, amplitude scale.
REQ-018 SHALL have port cfg_valid, output, 1, one-cycle pulse when any of wave_sel/freq_word/phase_word/amp changes.

Function
REQ-019 All outputs SHALL be registered; a press event SHALL be a key sampled low whose previous registered sample was high; the resulting output change SHALL be visible after the same rising edge that detects the event (1-cycle latency from first low sample).
REQ-020 A mode press SHALL advance mode 0->1->2->3->0 (wrap).
REQ-021 An up/down step SHALL act only on the parameter selected by mode: wave_sel +/-1 mod 4; freq_word +/-FREQ_STEP saturating at FREQ_MAX and 0; phase_word +/-PHASE_STEP mod 4096; amp +/-AMP_STEP saturating at 255 and 0.
REQ-022 Saturation arithmetic SHALL use at least one guard bit; a step that would overflow/underflow SHALL clamp to the limit, never wrap.
REQ-023 Auto-repeat: while up (or down) stays low, a further step SHALL occur HOLD_CYC cycles after the press step, then every REPEAT_CYC cycles; release SHALL clear the hold counter in the same cycle.
REQ-024 Up and down both low in the same cycle SHALL produce no step and SHALL clear both hold counters; repeat resumes only after a fresh press event.
REQ-025 A mode press coincident with an up/down step SHALL take priority: mode advances, step discarded, hold counters cleared.
REQ-026 A mode change while up/down is held SHALL halt auto-repeat until that key is released and pressed again.
REQ-027 cfg_valid SHALL pulse high exactly one cycle, aligned with the new output values, only when a value actually changed; a step clamped at a limit (no change) SHALL NOT pulse; mode changes alone SHALL NOT pulse.

Reset
REQ-028 While rst is high at a rising edge: mode=0, wave_sel=0, freq_word=FREQ_RST, phase_word=0, amp=8'd128, cfg_valid=0, hold counters=0, key sample registers=1 (released).
REQ-029 A key already held low when rst deasserts SHALL NOT produce a step until released and pressed again.
REQ-030 rst asserted mid-repeat SHALL abort repeat and restore all reset values on that edge.

Verification (bench with HOLD_CYC=8, REPEAT_CYC=4)
REQ-031 After reset, press mode once, then up once -> mode=1, freq_word=43950, one cfg_valid pulse.
REQ-032 mode=3, amp=240, press up twice -> amp=255 after first with cfg_valid, second step no change and no cfg_valid.
REQ-033 mode=2, phase_word=3840, press up -> phase_word=0, cfg_valid=1.
REQ-034 mode=1, hold up 20 cycles -> steps at press, +8, +12, +16, +20 cycles (5 steps), freq_word=FREQ_RST+5000.
REQ-035 Up and down pressed same cycle -> no output change, no cfg_valid; mode and up pressed same cycle with mode=0 -> mode=1, wave_sel unchanged.
REQ-036 Hold up low through rst deassertion -> no step until release and re-press; then exactly one step.
